pipe_rca_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; successor to the team's fixed 8-bit combinational carry-chain adder.
- Operand width is split into STAGES equal chunks. Each chunk is rippled by a chain of fulladder cells.
- Carry and skewed operands are registered between chunks, so throughput is one operation per clock.
- Valid/ready handshake on both sides with per-stage backpressure. Sits between operand-issue logic and result consumers in the datapath.

---
 rtl/adder_pkg.sv | 16 +
 rtl/fulladder.sv | 13 +
 rtl/rca_chunk.sv | 30 +++
 rtl/pipe_rca_adder.sv | 108 ++++++++++
 tb/tb_pipe_rca_adder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared configuration helpers for the pipelined ripple-carry adder.
package adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        if (stages < 1) return 1'b0;
        return (width % stages == 0) && (width >= stages);
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell used to build the ripple chains.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple of fulladder cells; also exposes the carry into the MSB.
module rca_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_c,
    output logic [CW-1:0] o_s,
    output logic          o_co,
    output logic          o_cmsb
);

    logic [CW:0] w_c;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        fulladder u_fa (
            .i_a  (i_a[i]),
            .i_b  (i_b[i]),
            .i_c  (w_c[i]),
            .o_s  (o_s[i]),
            .o_co (w_c[i+1])
        );
    end

    assign o_co   = w_c[CW];
    assign o_cmsb = w_c[CW-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk resolved per stage,
// valid/ready handshake with per-stage backpressure and bubble collapsing.
module pipe_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_bad
        $error("pipe_rca_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] sum_done;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             carry;
    } stage_t;

    logic [STAGES:0] w_rdy;
    logic            w_v    [STAGES];
    logic            w_up_v [STAGES];
    stage_t          w_pay  [STAGES];
    stage_t          w_up   [STAGES];
    stage_t          w_nxt  [STAGES];
    logic            w_co   [STAGES];
    logic            w_cmsb [STAGES];
    logic            r_ovf;

    assign w_rdy[STAGES] = out_ready;
    assign in_ready      = w_rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          r_v;
        stage_t        r_pay;
        logic [CW-1:0] w_s;

        assign w_rdy[k] = !r_v || w_rdy[k+1];
        assign w_v[k]   = r_v;
        assign w_pay[k] = r_pay;

        // Operand prep happens here so stage 0 latches chunk 0 already summed.
        if (k == 0) begin : g_head
            assign w_up_v[k] = in_valid;
            assign w_up[k]   = '{sum_done: '0, a_rem: a, b_rem: (sub ? ~b : b), carry: (sub | cin)};
        end else begin : g_body
            assign w_up_v[k] = w_v[k-1];
            assign w_up[k]   = w_pay[k-1];
        end

        rca_chunk #(.CW(CW)) u_chunk (
            .i_a    (w_up[k].a_rem[k*CW +: CW]),
            .i_b    (w_up[k].b_rem[k*CW +: CW]),
            .i_c    (w_up[k].carry),
            .o_s    (w_s),
            .o_co   (w_co[k]),
            .o_cmsb (w_cmsb[k])
        );

        always_comb begin
            w_nxt[k]                       = w_up[k];
            w_nxt[k].sum_done[k*CW +: CW]  = w_s;
            w_nxt[k].carry                 = w_co[k];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_pay <= '0;
            end else if (w_rdy[k]) begin
                r_v <= w_up_v[k];
                if (w_up_v[k]) r_pay <= w_nxt[k];
            end
        end

        if (k == STAGES-1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ovf <= 1'b0;
                else if (w_rdy[k] && w_up_v[k])
                    r_ovf <= w_cmsb[k] ^ w_co[k];
            end
        end
    end

    assign out_valid = w_v[STAGES-1];
    assign sum       = w_pay[STAGES-1].sum_done;
    assign cout      = w_pay[STAGES-1].carry;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Bench for pipe_rca_adder: directed 8-bit/2-stage cases plus randomized
// 32-bit streams (4 stages and 1 stage) against an arithmetic reference model.
module tb_pipe_rca_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;

    logic        iv32 [2];
    logic        ir32 [2];
    logic        cin32[2];
    logic        sub32[2];
    logic        ov32 [2];
    logic        or32 [2];
    logic        co32 [2];
    logic        of32 [2];
    logic [31:0] a32  [2];
    logic [31:0] b32  [2];
    logic [31:0] s32  [2];

    pipe_rca_adder #(.WIDTH(8), .STAGES(2)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    pipe_rca_adder #(.WIDTH(32), .STAGES(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32[0]), .in_ready(ir32[0]), .a(a32[0]), .b(b32[0]),
        .cin(cin32[0]), .sub(sub32[0]), .out_valid(ov32[0]), .out_ready(or32[0]), .sum(s32[0]),
        .cout(co32[0]), .ovf(of32[0])
    );

    pipe_rca_adder #(.WIDTH(32), .STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32[1]), .in_ready(ir32[1]), .a(a32[1]), .b(b32[1]),
        .cin(cin32[1]), .sub(sub32[1]), .out_valid(ov32[1]), .out_ready(or32[1]), .sum(s32[1]),
        .cout(co32[1]), .ovf(of32[1])
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit acc8, ret8, acc32, ret32;
    logic [33:0] q8[$];
    logic [33:0] q4[$];
    logic [33:0] q1[$];

    // Reference: {cout,sum} = a + b_eff + c_eff at width w; ovf when same-sign operands give other-sign sum.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] mask = (33'd1 << w) - 33'd1;
        logic [32:0] beff = {1'b0, (sub ? ~b : b)} & mask;
        logic [32:0] full = ({1'b0, a} & mask) + beff + (sub ? 33'd1 : {32'd0, cin});
        logic [31:0] s    = full[31:0] & mask[31:0];
        logic        co   = full[w];
        logic        ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        iv8 = iv; a8 = a; b8 = b; cin8 = cin; sub8 = sub; or8 = ordy;
        #1;
        acc8 = iv8 && ir8;
        ret8 = ov8 && or8;
        if (ret8) begin
            chk("r8_have", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) chk("r8_result", 64'({of8, co8, 24'd0, s8}), 64'(q8.pop_front()));
        end
        if (acc8) q8.push_back(model(8, {24'd0, a}, {24'd0, b}, cin, sub));
    endtask

    task automatic step32(input int d, input logic iv, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        iv32[d] = iv; a32[d] = a; b32[d] = b; cin32[d] = cin; sub32[d] = sub; or32[d] = ordy;
        #1;
        acc32 = iv32[d] && ir32[d];
        ret32 = ov32[d] && or32[d];
        if (ret32) begin
            if (d == 0) begin
                chk("r4_have", 64'(q4.size() > 0), 64'd1);
                if (q4.size() > 0) chk("r4_result", 64'({of32[d], co32[d], s32[d]}), 64'(q4.pop_front()));
            end else begin
                chk("r1_have", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) chk("r1_result", 64'({of32[d], co32[d], s32[d]}), 64'(q1.pop_front()));
            end
        end
        if (acc32) begin
            if (d == 0) q4.push_back(model(32, a, b, cin, sub));
            else        q1.push_back(model(32, a, b, cin, sub));
        end
    endtask

    // One beat with no backpressure; result must appear exactly 2 cycles after accept.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] es, input logic ec, input logic eo);
        int lat = 0;
        bit got = 0;
        step8(1'b1, a, b, cin, sub, 1'b1);
        chk({tag, "_acc"}, 64'(acc8), 64'd1);
        for (int i = 0; i < 10 && !got; i++) begin
            step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
            lat++;
            if (ret8) got = 1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        if (got) begin
            chk({tag, "_sum"},  64'(s8),  64'(es));
            chk({tag, "_cout"}, 64'(co8), 64'(ec));
            chk({tag, "_ovf"},  64'(of8), 64'(eo));
        end
    endtask

    logic [7:0] ta[3] = '{8'hFF, 8'h01, 8'hAA};
    logic [7:0] tb[3] = '{8'h01, 8'h01, 8'h55};
    logic [7:0] es[3] = '{8'h00, 8'h02, 8'hFF};
    logic       ec[3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] ba[5] = '{8'h12, 8'hF0, 8'h7F, 8'h80, 8'h00};
    logic [7:0] bb[5] = '{8'h34, 8'h20, 8'h7F, 8'h80, 8'h00};

    initial begin
        int k, first, last, j, nret, n_acc, n_ret;
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 0;
        for (int d = 0; d < 2; d++) begin
            iv32[d] = 0; a32[d] = 0; b32[d] = 0; cin32[d] = 0; sub32[d] = 0; or32[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready8",  64'(ir8), 64'd1);
        chk("rst_out_valid8", 64'(ov8), 64'd0);
        chk("rst_sum8",       64'(s8),  64'd0);
        chk("rst_cout8",      64'(co8), 64'd0);
        chk("rst_ovf8",       64'(of8), 64'd0);
        chk("rst_in_ready32", 64'({ir32[0], ir32[1]}), 64'd3);
        chk("rst_out_valid32", 64'({ov32[0], ov32[1]}), 64'd0);

        op8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_neg",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        k = 0; first = -1; last = -1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step8(1'b1, ta[i], tb[i], 1'b0, 1'b0, 1'b1);
            else       step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
            if (ret8 && k < 3) begin
                chk("b2b_sum",  64'(s8),  64'(es[k]));
                chk("b2b_cout", 64'(co8), 64'(ec[k]));
                if (k == 0) first = i;
                last = i;
                k++;
            end
        end
        chk("b2b_count", 64'(k), 64'd3);
        chk("b2b_first", 64'(first), 64'd2);
        chk("b2b_last",  64'(last),  64'd4);

        j = 0;
        for (int c = 0; c < 5; c++) begin
            step8(1'b1, ba[j], bb[j], 1'b0, 1'b0, 1'b0);
            if (acc8) j++;
            if (c >= 2) begin
                chk("bp_in_ready_low", 64'(ir8), 64'd0);
                chk("bp_out_valid",    64'(ov8), 64'd1);
                if (q8.size() > 0) chk("bp_hold", 64'({of8, co8, 24'd0, s8}), 64'(q8[0]));
            end
        end
        chk("bp_accepted_during_stall", 64'(j), 64'd2);
        nret = 0;
        for (int c = 0; c < 20 && nret < 4; c++) begin
            step8(j < 4, ba[j], bb[j], 1'b0, 1'b0, 1'b1);
            if (acc8) j++;
            if (ret8) nret++;
        end
        chk("bp_all_accepted", 64'(j), 64'd4);
        chk("bp_drained", 64'(nret), 64'd4);
        chk("bp_queue_empty", 64'(q8.size()), 64'd0);

        step8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        step8(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        iv8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(ov8), 64'd0);
        chk("mid_rst_sum",       64'(s8),  64'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        nret = 0;
        for (int c = 0; c < 4; c++) begin
            step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
            if (ret8) nret++;
        end
        chk("mid_rst_no_stale", 64'(nret), 64'd0);
        op8("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            n_acc = 0; n_ret = 0;
            for (int c = 0; c < 400; c++) begin
                step32(d, ($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
                if (acc32) n_acc++;
                if (ret32) n_ret++;
            end
            for (int c = 0; c < 50 && n_ret < n_acc; c++) begin
                step32(d, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
                if (ret32) n_ret++;
            end
            chk(d == 0 ? "rand4_balance" : "rand1_balance", 64'(n_ret), 64'(n_acc));
            chk(d == 0 ? "rand4_queue" : "rand1_queue",
                64'(d == 0 ? q4.size() : q1.size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
